thermo_edge_encoder_pipe: RTL

//  Pipelined, parametrised encoder for TDC delay-line edge vectors: converts an N_BITS-wide

---
 rtl/thermo_edge_encoder_pipe_if.sv | 31 +++
 rtl/thermo_edge_encoder_pipe.sv | 110 +++++++++++
 2 files changed

// File: rtl/thermo_edge_encoder_pipe_if.sv
// Bus between the delay-line sampling registers and the edge encoder:
// edge vector and tolerance in, fine-time code, flags and statistics out.
interface thermo_edge_encoder_pipe_if #(
   parameter int N_BITS = 64,
   parameter int LVL_W  = 4,
   parameter int CNT_W  = 16
);
   localparam int OUT_W = $clog2(N_BITS);

   logic              din_valid;
   logic [N_BITS-1:0] din;
   logic [LVL_W-1:0]  level;
   logic              cnt_clear;
   logic              dout_valid;
   logic [OUT_W-1:0]  dout;
   logic              bubble_o;
   logic              error_o;
   logic              empty_o;
   logic [CNT_W-1:0]  err_cnt;
   logic [CNT_W-1:0]  bubble_cnt;

   modport master (
      output din_valid, din, level, cnt_clear,
      input  dout_valid, dout, bubble_o, error_o, empty_o, err_cnt, bubble_cnt
   );

   modport slave (
      input  din_valid, din, level, cnt_clear,
      output dout_valid, dout, bubble_o, error_o, empty_o, err_cnt, bubble_cnt
   );
endinterface

// File: rtl/thermo_edge_encoder_pipe.sv
// Two-stage TDC edge encoder: finds the lowest/highest set tap, reports the floor
// midpoint, flags bubbles and out-of-tolerance spreads, and keeps saturating counts.
module thermo_edge_encoder_pipe #(
   parameter int N_BITS = 64,
   parameter int LVL_W  = 4,
   parameter int CNT_W  = 16
) (
   input logic clk,
   input logic reset,
   thermo_edge_encoder_pipe_if.slave bus
);
   localparam int OUT_W = $clog2(N_BITS);
   localparam int CMP_W = (OUT_W > LVL_W) ? OUT_W : LVL_W;

   logic [OUT_W-1:0] loIdx_d, hiIdx_d;
   logic             empty_d;

   logic             valid1_q;
   logic [OUT_W-1:0] loIdx_q, hiIdx_q;
   logic             empty1_q;
   logic [LVL_W-1:0] level1_q;

   logic [OUT_W-1:0] spread;
   logic [OUT_W-1:0] dout_d;
   logic             bubble_d, error_d;

   logic             doutValid_q;
   logic [OUT_W-1:0] dout_q;
   logic             bubble_q, error_q, empty2_q;
   logic [CNT_W-1:0] errCnt_q, bubbleCnt_q;

   // The last matching iteration wins, so scanning downward yields the lowest tap.
   always_comb begin
      loIdx_d = '0;
      hiIdx_d = '0;
      for (int i = N_BITS - 1; i >= 0; i--) begin
         if (bus.din[i]) loIdx_d = OUT_W'(i);
      end
      for (int i = 0; i < N_BITS; i++) begin
         if (bus.din[i]) hiIdx_d = OUT_W'(i);
      end
      empty_d = ~|bus.din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid1_q <= 1'b0;
         loIdx_q  <= '0;
         hiIdx_q  <= '0;
         empty1_q <= 1'b0;
         level1_q <= '0;
      end else begin
         valid1_q <= bus.din_valid;
         if (bus.din_valid) begin
            loIdx_q  <= loIdx_d;
            hiIdx_q  <= hiIdx_d;
            empty1_q <= empty_d;
            level1_q <= bus.level;
         end
      end
   end

   // An empty vector leaves lo = hi = 0, so the spread (and bubble) is already 0.
   always_comb begin
      spread   = hiIdx_q - loIdx_q;
      bubble_d = (spread != '0);
      error_d  = ~empty1_q & (CMP_W'(spread) >= CMP_W'(level1_q));
      dout_d   = (error_d | empty1_q) ? '0 : loIdx_q + (spread >> 1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         doutValid_q <= 1'b0;
         dout_q      <= '0;
         bubble_q    <= 1'b0;
         error_q     <= 1'b0;
         empty2_q    <= 1'b0;
      end else begin
         doutValid_q <= valid1_q;
         if (valid1_q) begin
            dout_q   <= dout_d;
            bubble_q <= bubble_d;
            error_q  <= error_d;
            empty2_q <= empty1_q;
         end
      end
   end

   // Counters sample the visible output flags; clear beats increment.
   always_ff @(posedge clk) begin
      if (reset) begin
         errCnt_q    <= '0;
         bubbleCnt_q <= '0;
      end else if (bus.cnt_clear) begin
         errCnt_q    <= '0;
         bubbleCnt_q <= '0;
      end else begin
         if (doutValid_q && error_q && !(&errCnt_q)) errCnt_q <= errCnt_q + CNT_W'(1);
         if (doutValid_q && bubble_q && !(&bubbleCnt_q)) bubbleCnt_q <= bubbleCnt_q + CNT_W'(1);
      end
   end

   assign bus.dout_valid = doutValid_q;
   assign bus.dout       = dout_q;
   assign bus.bubble_o   = bubble_q;
   assign bus.error_o    = error_q;
   assign bus.empty_o    = empty2_q;
   assign bus.err_cnt    = errCnt_q;
   assign bus.bubble_cnt = bubbleCnt_q;
endmodule
